// File: rtl/thor2023_imm_collector_if.sv
// thor2023_imm_collector_if: parcel-in / record-out bundle for the immediate collector.
// Latency: none (wires only); timing is set by the collector.
// Backpressure: valid/ready on both sides; the slave drives in_ready_o and out_valid_o.
// Ports: in_* carries parcels from fetch alignment, out_* carries the assembled record to decode,
//        orphan_o flags a discarded stray prefix.
interface thor2023_imm_collector_if #(
    parameter int WID = 96
);
    localparam int NW = $clog2(WID / 32 + 1);

    logic            in_valid_i;
    logic            in_ready_o;
    logic [39:0]     in_ir_i;
    logic [WID-1:0]  in_imm_i;
    logic [1:0]      in_ext_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [39:0]     out_ir_o;
    logic [WID-1:0]  out_imm_o;
    logic [7:0]      out_inc_o;
    logic [NW-1:0]   out_npfx_o;
    logic            orphan_o;

    modport slave (
        input  in_valid_i, in_ir_i, in_imm_i, in_ext_i, out_ready_i,
        output in_ready_o, out_valid_o, out_ir_o, out_imm_o, out_inc_o, out_npfx_o, orphan_o
    );

    modport master (
        output in_valid_i, in_ir_i, in_imm_i, in_ext_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_ir_o, out_imm_o, out_inc_o, out_npfx_o, orphan_o
    );
endinterface

// File: rtl/thor2023_imm_collector.sv
// thor2023_imm_collector: captures a base instruction, absorbs trailing OP_PFX parcels, emits one record.
// Latency: record valid one cycle after the terminator, the last prefix slot, or drain_i.
// Backpressure: in_ready low in EMIT and for any non-continuing parcel in COLLECT; record held until out_ready_i.
// Ports: clk_i/rst_i (sync, active high), flush_i (same effect as reset), drain_i (force emit),
//        bus (slave modport): parcel input handshake, record output handshake, orphan_o pulse.
module thor2023_imm_collector #(
    parameter int WID    = 96,
    parameter int NSLOT  = WID / 32,
    parameter int PBYTES = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     drain_i,
    thor2023_imm_collector_if.slave  bus
);
    localparam int         NW     = $clog2(NSLOT + 1);
    // Parcel layout: [5:0] opcode, [7:6] prefix slot (sz), [39:8] payload.
    localparam logic [5:0] OP_PFX = 6'h3F;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t          state_q, state_d;
    logic [39:0]     ir_q, ir_d;
    logic [WID-1:0]  imm_q, imm_d;
    logic [1:0]      ext_q, ext_d;
    logic [NW-1:0]   npfx_q, npfx_d;
    logic [7:0]      next_slot_q, next_slot_d;
    logic            out_valid_q, out_valid_d;
    logic [39:0]     out_ir_q, out_ir_d;
    logic [WID-1:0]  out_imm_q, out_imm_d;
    logic [7:0]      out_inc_q, out_inc_d;
    logic [NW-1:0]   out_npfx_q, out_npfx_d;
    logic            orphan_q, orphan_d;

    logic            is_pfx, in_seq, emit, in_ready;
    logic [7:0]      slot;
    logic [31:0]     payload, fill;
    logic [WID-1:0]  imm_pfx;

    // Parcel classification and the immediate that results if the presented prefix is absorbed.
    always_comb begin
        is_pfx  = (bus.in_ir_i[5:0] == OP_PFX);
        slot    = {6'd0, bus.in_ir_i[7:6]};
        payload = bus.in_ir_i[39:8];
        // First prefix may land in any slot; later ones must continue upward without gaps.
        if (npfx_q == '0) in_seq = is_pfx && (slot < 8'(NSLOT));
        else              in_seq = is_pfx && (slot == next_slot_q);
        case (ext_q)
            2'd1:    fill = '0;
            2'd2:    fill = '1;
            default: fill = {32{payload[31]}};
        endcase
        imm_pfx = '0;
        for (int j = 0; j < NSLOT; j++) begin
            if (j < int'(slot))
                // The base short-form immediate is meaningless once a prefix builds the value.
                imm_pfx[32*j +: 32] = (npfx_q == '0) ? 32'd0 : imm_q[32*j +: 32];
            else if (j == int'(slot))
                imm_pfx[32*j +: 32] = payload;
            else
                imm_pfx[32*j +: 32] = fill;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        ext_d       = ext_q;
        npfx_d      = npfx_q;
        next_slot_d = next_slot_q;
        out_valid_d = out_valid_q;
        out_ir_d    = out_ir_q;
        out_imm_d   = out_imm_q;
        out_inc_d   = out_inc_q;
        out_npfx_d  = out_npfx_q;
        orphan_d    = 1'b0;
        in_ready    = 1'b0;
        emit        = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid_i) begin
                    if (is_pfx) begin
                        orphan_d = 1'b1;
                    end else begin
                        ir_d        = bus.in_ir_i;
                        imm_d       = bus.in_imm_i;
                        ext_d       = bus.in_ext_i;
                        npfx_d      = '0;
                        next_slot_d = '0;
                        state_d     = COLLECT;
                    end
                end
            end
            COLLECT: begin
                in_ready = in_seq;
                if (bus.in_valid_i && in_seq) begin
                    imm_d       = imm_pfx;
                    npfx_d      = npfx_q + NW'(1);
                    next_slot_d = slot + 8'd1;
                    // Top slot filled: nothing can follow, so close without waiting.
                    emit        = (slot == 8'(NSLOT - 1));
                end else if (bus.in_valid_i || drain_i) begin
                    // Terminator is left on the bus and re-presented to IDLE as the next base.
                    emit = 1'b1;
                end
            end
            EMIT: begin
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            state_d     = EMIT;
            out_valid_d = 1'b1;
            out_ir_d    = ir_q;
            out_imm_d   = imm_d;
            out_npfx_d  = npfx_d;
            out_inc_d   = 8'(PBYTES) * (8'(npfx_d) + 8'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            imm_q       <= '0;
            ext_q       <= '0;
            npfx_q      <= '0;
            next_slot_q <= '0;
            out_valid_q <= 1'b0;
            out_ir_q    <= '0;
            out_imm_q   <= '0;
            out_inc_q   <= '0;
            out_npfx_q  <= '0;
            orphan_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            imm_q       <= imm_d;
            ext_q       <= ext_d;
            npfx_q      <= npfx_d;
            next_slot_q <= next_slot_d;
            out_valid_q <= out_valid_d;
            out_ir_q    <= out_ir_d;
            out_imm_q   <= out_imm_d;
            out_inc_q   <= out_inc_d;
            out_npfx_q  <= out_npfx_d;
            orphan_q    <= orphan_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_ir_o    = out_ir_q;
    assign bus.out_imm_o   = out_imm_q;
    assign bus.out_inc_o   = out_inc_q;
    assign bus.out_npfx_o  = out_npfx_q;
    assign bus.orphan_o    = orphan_q;
endmodule

// File: tb/tb_thor2023_imm_collector.sv
// tb_thor2023_imm_collector: vector table, corner sequences and a random stream vs. a parcel-level model.
// Latency: checks the one-cycle record latency after terminator / last slot / drain.
// Backpressure: exercises held records, in_ready gating and random out_ready.
module tb_thor2023_imm_collector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush, drain, flush2, drain2;
    int   total = 0;
    int   bad   = 0;

    thor2023_imm_collector_if #(.WID(96))  bus ();
    thor2023_imm_collector_if #(.WID(128)) bus2 ();

    thor2023_imm_collector #(.WID(96)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .drain_i(drain), .bus(bus));
    thor2023_imm_collector #(.WID(128)) dut2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush2), .drain_i(drain2), .bus(bus2));

    typedef struct {
        logic [95:0]      bimm;
        logic [1:0]       ext;
        int               np;
        logic [2:0][1:0]  sz;
        logic [2:0][31:0] pl;
        int               term;   // 0 none (last slot), 1 non-prefix, 2 prefix tsz, 3 drain
        logic [1:0]       tsz;
        logic [95:0]      eimm;
        logic [7:0]       einc;
        logic [1:0]       enp;
        logic             eorph;
    } vec_t;

    typedef struct packed {
        logic [39:0] ir;
        logic [95:0] imm;
        logic [1:0]  ext;
    } parcel_t;

    typedef struct packed {
        logic [39:0] ir;
        logic [95:0] imm;
        logic [7:0]  inc;
        logic [1:0]  np;
    } rec_t;

    vec_t    vt [11];
    parcel_t pq [$];
    rec_t    rq [$];
    int      orph_exp;
    bit      drv_done, mon_done;

    function automatic logic [39:0] mk_pfx(input logic [1:0] sz, input logic [31:0] pl);
        return {pl, sz, 6'h3F};
    endfunction

    function automatic logic [39:0] mk_addi(input logic [31:0] f);
        return {f, 2'b00, 6'h04};
    endfunction

    function automatic vec_t mkv(input logic [95:0] bimm, input logic [1:0] ext, input int np,
                                 input logic [1:0] s0, input logic [31:0] p0,
                                 input logic [1:0] s1, input logic [31:0] p1,
                                 input logic [1:0] s2, input logic [31:0] p2,
                                 input int term, input logic [1:0] tsz, input logic [95:0] eimm,
                                 input logic [7:0] einc, input logic [1:0] enp, input logic eorph);
        vec_t v;
        v.bimm = bimm; v.ext = ext; v.np = np;
        v.sz[0] = s0; v.sz[1] = s1; v.sz[2] = s2;
        v.pl[0] = p0; v.pl[1] = p1; v.pl[2] = p2;
        v.term = term; v.tsz = tsz; v.eimm = eimm; v.einc = einc; v.enp = enp; v.eorph = eorph;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds the parcel valid until the collector takes it (bounded).
    task automatic send(input logic [39:0] ir, input logic [95:0] imm, input logic [1:0] ext);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.in_ir_i = ir; bus.in_imm_i = imm; bus.in_ext_i = ext; bus.in_valid_i = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid_i = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: parcel %h never accepted", ir);
        end
    endtask

    task automatic wait_rec(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = bus.out_valid_o;
        end
    endtask

    task automatic accept();
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.out_ready_i = 1'b0;
    endtask

    task automatic pulse_drain();
        drain = 1'b1;
        @(posedge clk); #1;
        drain = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Parcel-stream reference: groups parcels into records directly from the prefix rules.
    task automatic model_build();
        bit         open;
        int         n, last, k;
        rec_t       cur;
        logic [1:0] cext;
        logic       pf;
        logic [31:0] pl;
        logic [95:0] lo, mid, hi, fillv;
        open = 1'b0; n = 0; last = 0; orph_exp = 0; cur = '0; cext = 2'd0;
        foreach (pq[i]) begin
            pf = (pq[i].ir[5:0] == 6'h3F);
            k  = int'(pq[i].ir[7:6]);
            pl = pq[i].ir[39:8];
            if (open) begin
                if (pf && ((n == 0) ? (k < 3) : (k == last + 1))) begin
                    lo    = (n == 0) ? 96'd0 : (cur.imm & ((96'd1 << (32 * k)) - 96'd1));
                    mid   = {64'd0, pl} << (32 * k);
                    fillv = (cext == 2'd1) ? '0 : (cext == 2'd2) ? '1 : {96{pl[31]}};
                    hi    = fillv << (32 * k + 32);
                    cur.imm = lo | mid | hi;
                    n++;
                    last = k;
                    if (k == 2) begin
                        cur.inc = 8'(5 * (n + 1)); cur.np = 2'(n);
                        rq.push_back(cur);
                        open = 1'b0;
                    end
                    continue;
                end
                cur.inc = 8'(5 * (n + 1)); cur.np = 2'(n);
                rq.push_back(cur);
                open = 1'b0;
            end
            if (pf) begin
                orph_exp++;
            end else begin
                open = 1'b1; n = 0;
                cur.ir = pq[i].ir; cur.imm = pq[i].imm; cext = pq[i].ext;
            end
        end
        if (open) begin
            cur.inc = 8'(5 * (n + 1)); cur.np = 2'(n);
            rq.push_back(cur);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; drain = 1'b0; flush2 = 1'b0; drain2 = 1'b0;
        bus.in_valid_i = 1'b0; bus.in_ir_i = '0; bus.in_imm_i = '0; bus.in_ext_i = '0; bus.out_ready_i = 1'b0;
        bus2.in_valid_i = 1'b0; bus2.in_ir_i = '0; bus2.in_imm_i = '0; bus2.in_ext_i = '0; bus2.out_ready_i = 1'b0;
        drv_done = 1'b0; mon_done = 1'b0;

        vt[0]  = mkv(96'hFFFFFFFF_FFFFFFFF_FFFFFFF3, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     96'hFFFFFFFF_FFFFFFFF_FFFFFFF3, 8'd5, 2'd0, 1'b0);
        vt[1]  = mkv(96'h7, 2'd0, 1, 0, 32'h80000001, 0, 0, 0, 0, 1, 0,
                     96'hFFFFFFFF_FFFFFFFF_80000001, 8'd10, 2'd1, 1'b0);
        vt[2]  = mkv(96'h0, 2'd0, 3, 0, 32'h11111111, 1, 32'h22222222, 2, 32'h33333333, 0, 0,
                     96'h33333333_22222222_11111111, 8'd20, 2'd3, 1'b0);
        vt[3]  = mkv({96{1'b1}}, 2'd1, 1, 1, 32'h0000ABCD, 0, 0, 0, 0, 2, 2'd0,
                     96'h00000000_0000ABCD_00000000, 8'd10, 2'd1, 1'b1);
        vt[4]  = mkv(96'h5, 2'd2, 1, 0, 32'h00000005, 0, 0, 0, 0, 3, 0,
                     96'hFFFFFFFF_FFFFFFFF_00000005, 8'd10, 2'd1, 1'b0);
        vt[5]  = mkv({96{1'b1}}, 2'd3, 1, 1, 32'h7FFFFFFF, 0, 0, 0, 0, 3, 0,
                     96'h00000000_7FFFFFFF_00000000, 8'd10, 2'd1, 1'b0);
        vt[6]  = mkv(96'h0, 2'd1, 2, 0, 32'hDEADBEEF, 1, 32'hCAFEF00D, 0, 0, 2, 2'd3,
                     96'h00000000_CAFEF00D_DEADBEEF, 8'd15, 2'd2, 1'b1);
        vt[7]  = mkv({96{1'b1}}, 2'd2, 1, 2, 32'h12345678, 0, 0, 0, 0, 0, 0,
                     96'h12345678_00000000_00000000, 8'd10, 2'd1, 1'b0);
        vt[8]  = mkv(96'h42, 2'd0, 0, 0, 0, 0, 0, 0, 0, 3, 0,
                     96'h42, 8'd5, 2'd0, 1'b0);
        vt[9]  = mkv(96'h0, 2'd0, 1, 0, 32'h00000001, 0, 0, 0, 0, 2, 2'd2,
                     96'h1, 8'd10, 2'd1, 1'b1);
        vt[10] = mkv(96'h9, 2'd0, 2, 1, 32'h80000000, 2, 32'h00000001, 0, 0, 0, 0,
                     96'h00000001_80000000_00000000, 8'd15, 2'd2, 1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", {bus.out_valid_o, bus.out_ir_o, bus.out_imm_o, bus.out_inc_o,
                          bus.out_npfx_o, bus.orphan_o}, '0);
        check("rst_out128", {bus2.out_valid_o, bus2.out_imm_o, bus2.out_inc_o, bus2.orphan_o}, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_rdy", bus.in_ready_o, 1'b1);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            vec_t        v;
            logic [39:0] base, term_ir;
            bit          ok;
            v       = vt[i];
            base    = mk_addi(32'h00001000 + i);
            term_ir = mk_addi(32'hBEEF0000 + i);
            pulse_flush();
            send(base, v.bimm, v.ext);
            for (int p = 0; p < v.np; p++) send(mk_pfx(v.sz[p], v.pl[p]), '0, v.ext);
            if (v.term == 2) term_ir = mk_pfx(v.tsz, 32'h0BAD0BAD);
            if (v.term == 1 || v.term == 2) begin
                bus.in_ir_i = term_ir; bus.in_valid_i = 1'b1;
            end else if (v.term == 3) begin
                pulse_drain();
            end
            wait_rec(ok);
            check($sformatf("v%0d_valid", i), ok, 1'b1);
            check($sformatf("v%0d_imm", i), bus.out_imm_o, v.eimm);
            check($sformatf("v%0d_meta", i), {bus.out_ir_o, bus.out_inc_o, bus.out_npfx_o},
                  {base, v.einc, v.enp});
            if (v.term == 1 || v.term == 2)
                check($sformatf("v%0d_term_blocked", i), bus.in_ready_o, 1'b0);
            accept();
            if (v.term == 1 || v.term == 2) begin
                send(term_ir, '0, v.ext);
                @(negedge clk);
                check($sformatf("v%0d_orphan", i), bus.orphan_o, v.eorph);
                @(posedge clk); #1;
            end
        end

        // Held record stays stable, then one bubble cycle after acceptance
        begin
            bit ok;
            pulse_flush();
            send(mk_addi(32'h2222), 96'h77, 2'd1);
            send(mk_pfx(2'd0, 32'hAABBCCDD), '0, 2'd1);
            pulse_drain();
            wait_rec(ok);
            for (int c = 0; c < 5; c++) begin
                check($sformatf("hold_c%0d", c),
                      {ok, bus.out_valid_o, bus.out_imm_o, bus.out_inc_o, bus.out_npfx_o},
                      {1'b1, 1'b1, 96'h00000000_00000000_AABBCCDD, 8'd10, 2'd1});
                @(posedge clk); @(negedge clk);
            end
            accept();
            @(negedge clk);
            check("bubble", {bus.out_valid_o, bus.in_ready_o}, 2'b01);
            @(posedge clk); #1;
        end

        // Flush mid-collect drops the instruction; drain in IDLE does nothing
        begin
            logic seen;
            pulse_flush();
            send(mk_addi(32'h3333), 96'h1, 2'd0);
            send(mk_pfx(2'd0, 32'h44444444), '0, 2'd0);
            @(negedge clk);
            check("collect_rdy_stale", bus.in_ready_o, 1'b0);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            @(negedge clk);
            check("flush_idle", {bus.out_valid_o, bus.in_ready_o}, 2'b01);
            drain = 1'b1;
            @(posedge clk); #1;
            drain = 1'b0;
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                seen = seen | bus.out_valid_o;
            end
            check("drain_idle_noop", seen, 1'b0);
            @(posedge clk); #1;
        end

        // WID=128: ones extension from slot 1, closed by drain with no parcel valid
        bus2.in_ir_i = mk_addi(32'h5555); bus2.in_imm_i = 128'h1234; bus2.in_ext_i = 2'd2;
        bus2.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus2.in_ir_i = mk_pfx(2'd1, 32'hA5A5A5A5);
        @(posedge clk); #1;
        bus2.in_valid_i = 1'b0;
        drain2 = 1'b1;
        @(posedge clk); #1;
        drain2 = 1'b0;
        @(negedge clk);
        check("w128_imm", {bus2.out_valid_o, bus2.out_imm_o},
              {1'b1, 64'hFFFFFFFF_FFFFFFFF, 32'hA5A5A5A5, 32'h00000000});
        check("w128_meta", {bus2.out_ir_o, bus2.out_inc_o, bus2.out_npfx_o},
              {mk_addi(32'h5555), 8'd10, 3'd1});
        bus2.out_ready_i = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready_i = 1'b0;

        // Random stream against the parcel-level model
        for (int g = 0; g < 70; g++) begin
            parcel_t p;
            int      c, s, sz;
            if ($urandom % 10 == 0) begin
                p.ir  = mk_pfx(2'($urandom % 4), $urandom);
                p.imm = {$urandom, $urandom, $urandom};
                p.ext = 2'($urandom % 4);
                pq.push_back(p);
            end else begin
                p.ir  = {$urandom, 2'($urandom % 4), 6'($urandom % 63)};
                p.imm = {$urandom, $urandom, $urandom};
                p.ext = 2'($urandom % 4);
                pq.push_back(p);
                c = int'($urandom % 4);
                s = int'($urandom % 3);
                for (int j = 0; j < c; j++) begin
                    sz = ($urandom % 6 == 0) ? int'($urandom % 4) : ((s + j > 3) ? 3 : s + j);
                    p.ir  = mk_pfx(2'(sz), $urandom);
                    p.imm = {$urandom, $urandom, $urandom};
                    p.ext = 2'($urandom % 4);
                    pq.push_back(p);
                end
            end
        end
        model_build();
        pulse_flush();

        fork
            begin
                foreach (pq[i]) begin
                    if ($urandom % 3 == 0) begin
                        @(posedge clk); #1;
                    end
                    send(pq[i].ir, pq[i].imm, pq[i].ext);
                end
                @(posedge clk); #1;
                pulse_drain();
                drv_done = 1'b1;
            end
            begin
                int got, cyc, tail, orph_seen;
                got = 0; cyc = 0; tail = 0; orph_seen = 0;
                while (cyc < 20000 && !(drv_done && got >= rq.size() && tail >= 4)) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.orphan_o) orph_seen++;
                    if (bus.out_valid_o && bus.out_ready_i) begin
                        if (got < rq.size())
                            check($sformatf("rand_rec%0d", got),
                                  {bus.out_ir_o, bus.out_imm_o, bus.out_inc_o, bus.out_npfx_o},
                                  {rq[got].ir, rq[got].imm, rq[got].inc, rq[got].np});
                        got++;
                    end
                    if (drv_done && got >= rq.size()) tail++;
                end
                check("rand_count", got, rq.size());
                check("rand_orphans", orph_seen, orph_exp);
                mon_done = 1'b1;
            end
            begin
                while (!mon_done) begin
                    @(posedge clk); #1;
                    bus.out_ready_i = ($urandom % 3 != 0);
                end
                bus.out_ready_i = 1'b0;
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/thor2023_imm_collector.md
Name: thor2023_imm_collector

Overview:
- Sequential successor to the combinational immediate decoder.
- Accepts a stream of 40-bit instruction parcels over a valid/ready handshake.
- Captures a base instruction, absorbs any trailing OP_PFX parcels, and emits one registered record: instruction, full-width immediate, PC increment and prefix count.
- Generalised to any immediate width that is a multiple of 32. Adds drain, flush and orphan-prefix detection.
- Sits between fetch alignment and decode.

Parameters:
- WID, 96: immediate width in bits; must be a multiple of 32.
- NSLOT, WID/32: number of 32-bit prefix slots (derived; do not override).
- PBYTES, 5: bytes per parcel, used for the increment.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  synchronous discard of all state; same effect as reset.
- drain_i  in  1  force emit of the instruction being collected.
- in_valid_i  in  1  parcel valid.
- in_ready_o  out  1  parcel accepted when in_valid_i & in_ready_o.
- in_ir_i  in  40  parcel (instruction_t).
- in_imm_i  in  WID  base immediate from the short-form decoder, used only when no prefix follows.
- in_ext_i  in  2  extension mode for prefix-built immediates: 0 sign, 1 zero, 2 ones, 3 sign.
- out_valid_o  out  1  record valid.
- out_ready_i  in  1  consumer accept.
- out_ir_o  out  40  base instruction.
- out_imm_o  out  WID  assembled immediate.
- out_inc_o  out  8  PC increment = PBYTES*(1+npfx).
- out_npfx_o  out  $clog2(NSLOT+1)  number of prefixes absorbed.
- orphan_o  out  1  one-cycle pulse when a prefix with no base instruction is discarded.

Behaviour:
- Definitions:
  - Parcel is a prefix when in_ir_i.any.opcode==OP_PFX.
  - slot = in_ir_i.any.sz.
  - payload = in_ir_i[39:8].
- States: IDLE, COLLECT, EMIT.
- Reset/flush values:
  - State IDLE.
  - out_valid_o=0, out_ir_o=0, out_imm_o=0, out_inc_o=0, out_npfx_o=0, orphan_o=0.
  - Any partially collected instruction is dropped.
  - flush_i has priority over every other input.
- in_ready_o is combinational:
  - IDLE: 1.
  - COLLECT: 1 only if the parcel is an in-sequence prefix (rules below); else 0.
  - EMIT: 0.
- IDLE:
  - Accepted non-prefix parcel: capture ir, imm←in_imm_i, ext←in_ext_i, npfx=0, next_slot=any → COLLECT.
  - Accepted prefix: discard, pulse orphan_o next cycle, stay IDLE.
- COLLECT, prefix handling:
  - The first prefix may have any slot s < NSLOT. Each later prefix must have slot == previous+1.
  - On an accepted in-sequence prefix with slot k:
    - First prefix only: imm bits below 32k are zeroed.
    - imm[32k+31:32k] = payload.
    - imm bits above 32k+31 are filled per ext: sign copies payload[31], zero fills 0, ones fills 1.
    - npfx++.
  - If k==NSLOT-1, go to EMIT immediately (no further prefix is possible).
  - A prefix with slot ≥ NSLOT, or out of sequence, is treated as a terminator.
- COLLECT, termination:
  - An in_valid_i terminator (non-prefix or out-of-sequence prefix) is not consumed; go to EMIT.
  - drain_i=1 with no valid in-sequence prefix presented also goes to EMIT.
  - Otherwise wait.
- EMIT:
  - Record registered; out_valid_o=1 and held stable until out_ready_i.
  - On the handshake → IDLE; out_valid_o=0 next cycle.
  - One bubble cycle after every record is accepted.
- Latency: record valid 1 cycle after the terminating event (terminator seen, last slot written, or drain).
- out_inc_o = PBYTES*(1+npfx), e.g. 5, 10, 15, 20 for WID=96.
- A terminator held in COLLECT is re-presented upstream and accepted in IDLE as the next base instruction.
- drain_i in IDLE or EMIT has no effect.

Test Plan:
- ADDI parcel with in_imm_i=0x…FFF3, then a non-prefix parcel → out_imm=in_imm_i, inc=5, npfx=0, in_ready low for the second parcel until the record is accepted.
- ADDI, then PFX sz0 payload 0x80000001, then non-prefix, ext=sign → imm=0xFFFFFFFF_FFFFFFFF_80000001, inc=10, npfx=1.
- ADDI, then PFX sz0 0x11111111, sz1 0x22222222, sz2 0x33333333 (WID=96) → imm=0x33333333_22222222_11111111, inc=20, npfx=3, EMIT entered without waiting for a terminator.
- ADDI, then PFX sz1 0x0000ABCD, then PFX sz0, ext=zero → imm=0x0000ABCD_00000000 (low slot zeroed), npfx=1, the sz0 prefix is not consumed and is later discarded with orphan_o=1.
- Record held with out_ready_i=0 for 5 cycles → outputs stable throughout; flush_i asserted mid-COLLECT → no record, IDLE next cycle.
- WID=128, ext=ones, PFX sz1 only → bits[127:64] all ones, bits[63:32]=payload, bits[31:0]=0; drain_i with in_valid_i=0 → record emitted.
